text_console_writer: RTL and testbench
======================================

Name: text_console_writer

Overview:
- Write-side companion to the VGA text-mode display engine.
- Accepts a byte stream over a valid/ready handshake and interprets it as terminal output: printable characters, CR, LF, BS and FF.
- Writes character codes into the dual-port character buffer that the display engine reads. The buffer is an 80x25 grid, row-major, address = row*80 + col.
- Maintains the cursor, auto-wraps at the end of a line, and scrolls the screen up by copying rows through the buffer's second port.

Parameters:
- COLS, 80, characters per row.
- ROWS, 25, rows on screen.
- ADDR_W, 11, buffer address width; must satisfy 2^ADDR_W >= COLS*ROWS.
- BLANK, 8'h20, code written when clearing cells.

Ports:
- clk  in  1  system clock, same domain as the display engine.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  8  byte to interpret.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a byte this cycle.
- wr_en  out  1  buffer write strobe (registered).
- wr_addr  out  ADDR_W  buffer write address (registered).
- wr_data  out  8  buffer write data (registered).
- rd_addr  out  ADDR_W  buffer read address (registered). The buffer returns its contents on rd_data one cycle later.
- rd_data  in  8  buffer read data.
- cursor_pos  out  ADDR_W  current cursor address, row*COLS + col.
- busy  out  1  high in any non-IDLE state; equals !in_ready.

Behaviour:
- Reset (async, rst_n low):
  - State = CLEAR_ALL, clear counter = 0, cursor = 0.
  - wr_en = 0, wr_addr = 0, wr_data = BLANK, rd_addr = 0, in_ready = 0.
  - Deassertion of reset starts a full-screen clear.
- Handshake:
  - A byte is accepted on a rising edge where in_valid && in_ready.
  - in_ready = 1 only in IDLE.
  - Exactly one byte is accepted per cycle.
- Byte decode in IDLE (a byte accepted at edge N takes effect at edge N):
  - 0x20–0x7E, or any byte with bit7 set (inverse video, stored verbatim):
    - From the cycle after edge N: wr_en = 1, wr_addr = cursor, wr_data = byte.
    - Cursor advances. If col = COLS-1, col becomes 0 and the row advances.
    - If the row was already ROWS-1, cursor = (ROWS-1)*COLS and the state goes to SCROLL.
  - 0x0D (CR): col = 0; no write.
  - 0x0A (LF): row+1, col unchanged. On the last row: cursor = (ROWS-1)*COLS + col, state goes to SCROLL.
  - 0x08 (BS): if col > 0, col-1; else no change. No erase, no write.
  - 0x0C (FF): cursor = 0, state goes to CLEAR_ALL.
  - Any other byte below 0x20 (and 0x7F): ignored; the byte is still consumed.
  - wr_en = 0 in every cycle in which no write is scheduled.
- SCROLL state:
  - Source counter s runs from COLS to COLS*ROWS-1, one step per cycle; rd_addr = s.
  - One cycle later: wr_en = 1, wr_addr = s-COLS, wr_data = rd_data.
  - After the last read, one drain cycle completes the final write, then the state goes to CLEAR_ROW.
  - The write address is always below the read address, so there is no hazard.
- CLEAR_ROW state:
  - Writes BLANK to (ROWS-1)*COLS … COLS*ROWS-1, one cell per cycle, then returns to IDLE.
- CLEAR_ALL state:
  - Writes BLANK to 0 … COLS*ROWS-1, one cell per cycle, then returns to IDLE.
- Busy durations (defaults):
  - SCROLL+CLEAR_ROW: in_ready low for 1920 + 1 + 80 = 2001 cycles.
  - CLEAR_ALL: in_ready low for 2000 cycles.
- A print that wraps on the last row writes its character first (first cycle after acceptance), then the scroll starts. The written character therefore ends up on row ROWS-2 after the scroll.
- Arithmetic:
  - Row and col are held as separate counters.
  - cursor_pos = row*COLS + col, truncated to ADDR_W.
  - The cursor never exceeds COLS*ROWS-1.
- Reset asserted mid-SCROLL or mid-CLEAR aborts immediately: wr_en drops asynchronously, and the clear restarts after release.
- cursor_pos updates at the acceptance edge. During SCROLL and clears it holds its final value.

Test Plan:
- Reset release: watch the first 2001 cycles → in_ready stays 0 for exactly 2000 cycles; wr_addr sweeps 0..1999 with wr_data 0x20 each cycle; then in_ready = 1, cursor_pos = 0.
- Send "AB" then CR then "C" → writes 0x41@0, 0x42@1, 0x43@0; cursor_pos = 1. Send BS twice → cursor_pos = 0 after the second BS, no writes.
- Fill a row: 80 × 0x58 from cursor 0 → last write 0x58@79; cursor_pos = 80; no scroll.
- Preload the buffer model with row r holding value r; cursor at 1920; send LF → in_ready low for 2001 cycles. Afterwards rows 0..23 hold 1..24, row 24 holds 0x20, cursor_pos = 1920.
- Cursor at 1999, send 0x41 → write 0x41@1999, then scroll. Final buffer has 0x41@1919, cursor_pos = 1920. Send 0xC1 → write 0xC1@1920 verbatim.
- FF mid-screen: cursor 500, send 0x0C → 2000 BLANK writes, cursor_pos = 0. Repeat with rst_n pulsed low mid-scroll → wr_en drops immediately, then a full clear runs.

Source files
------------

// File: rtl/text_console_writer.sv
// text_console_writer
//   Write side of the VGA text-mode console. It interprets a byte stream as
//   terminal output and maintains the character buffer that the display
//   engine reads. The buffer is COLS x ROWS cells, row-major, and its address
//   is row*COLS + col.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_data/in_valid     byte stream in; in_ready is high only in IDLE
//   wr_en/wr_addr/wr_data  registered buffer write port
//   rd_addr/rd_data      registered read address; rd_data must be valid in the
//                        cycle after rd_addr changes
//   cursor_pos           row*COLS + col
//   busy                 !in_ready
//
// Bytes handled: printable bytes 0x20-0x7E and any byte with bit 7 set are
// written at the cursor. CR, LF, BS and FF move the cursor. FF also clears the
// screen. Any other byte is consumed and ignored. Scrolling copies rows 1..ROWS-1
// up by one row through the read port, then blanks the last row.
module text_console_writer #(
  parameter int          COLS   = 80,
  parameter int          ROWS   = 25,
  parameter int          ADDR_W = 11,
  parameter logic [7:0]  BLANK  = 8'h20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] cursor_pos,
  output logic              busy
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] LAST_A     = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] ROW_LAST_A = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  LAST_COL   = COL_W'(COLS - 1);

  typedef enum logic [1:0] {IDLE, SCROLL, CLEAR_ROW, CLEAR_ALL} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;       // sweep counter for scroll and clears
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic                rd_pend_q, rd_pend_d;  // rd_addr_q holds a read whose data is arriving
  logic                drain_q, drain_d;      // last scroll read issued; the next cycle only writes
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;

  logic accept, last_row, last_col, is_print;

  assign in_ready   = (state_q == IDLE);
  assign busy       = ~in_ready;
  assign accept     = in_valid & in_ready;
  assign last_row   = (row_q == LAST_ROW);
  assign last_col   = (col_q == LAST_COL);
  assign is_print   = in_data[7] | ((in_data >= 8'h20) & (in_data <= 8'h7E));
  assign cursor_pos = ADDR_W'(row_q) * COLS_A + ADDR_W'(col_q);

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_addr = rd_addr_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= CLEAR_ALL;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_print && last_row && last_col)  state_d = SCROLL;
          else if (in_data == 8'h0A && last_row) state_d = SCROLL;
          else if (in_data == 8'h0C)             state_d = CLEAR_ALL;
        end
      end
      SCROLL:    if (drain_q)         state_d = CLEAR_ROW;
      CLEAR_ROW: if (cnt_q == LAST_A) state_d = IDLE;
      CLEAR_ALL: if (cnt_q == LAST_A) state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    cnt_d     = cnt_q;
    row_d     = row_q;
    col_d     = col_q;
    rd_pend_d = 1'b0;
    drain_d   = drain_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_print) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cursor_pos;
            wr_data_d = in_data;
            if (last_col) begin
              col_d = '0;
              if (!last_row) row_d = row_q + ROW_W'(1);
              else begin
                cnt_d   = COLS_A;
                drain_d = 1'b0;
              end
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end else if (in_data == 8'h0D) begin
            col_d = '0;
          end else if (in_data == 8'h0A) begin
            if (!last_row) row_d = row_q + ROW_W'(1);
            else begin
              cnt_d   = COLS_A;
              drain_d = 1'b0;
            end
          end else if (in_data == 8'h08) begin
            if (col_q != '0) col_d = col_q - COL_W'(1);
          end else if (in_data == 8'h0C) begin
            row_d = '0;
            col_d = '0;
            cnt_d = '0;
          end
        end
      end

      // Read cell s, then one cycle later write its data one row up.
      // The write address trails the read address by a full row.
      SCROLL: begin
        if (rd_pend_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = rd_addr_q - COLS_A;
          wr_data_d = rd_data;
        end
        if (!drain_q) begin
          rd_addr_d = cnt_q;
          rd_pend_d = 1'b1;
          if (cnt_q == LAST_A) drain_d = 1'b1;
          else                 cnt_d   = cnt_q + ADDR_W'(1);
        end else begin
          cnt_d = ROW_LAST_A;
        end
      end

      CLEAR_ROW, CLEAR_ALL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_data_d = BLANK;
        if (cnt_q != LAST_A) cnt_d = cnt_q + ADDR_W'(1);
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      rd_pend_q <= 1'b0;
      drain_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= BLANK;
      rd_addr_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      col_q     <= col_d;
      rd_pend_q <= rd_pend_d;
      drain_q   <= drain_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer. A buffer model sits on the write and read
// ports. Stimulus pushes every expected write into a queue. A monitor pops
// the queue and compares on each wr_en seen at the falling edge.
`timescale 1ns/1ps
module tb_text_console_writer;

  localparam int AW = 11;
  localparam int TOTAL = 2000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [AW-1:0] cursor_pos;
  logic          busy;

  text_console_writer dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .cursor_pos(cursor_pos), .busy(busy)
  );

  always #5 clk = ~clk;

  // Buffer model: a write commits at the rising edge. Read data follows
  // rd_addr, so it is valid in the cycle after the DUT registers rd_addr.
  logic [7:0] mem [0:2047];
  logic       preload = 1'b0;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < TOTAL; i++) mem[i] <= 8'(i / 80);
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end
  assign rd_data = mem[rd_addr];

  typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;
  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] ref_mem [0:2047];
  int         errors = 0;
  int         checks = 0;

  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got %02h@%0d, required no write", wr_data, wr_addr);
      end else begin
        mon_e = exp_q.pop_front();
        if (wr_addr !== mon_e.a || wr_data !== mon_e.d) begin
          errors++;
          $display("FAIL wr: got %02h@%0d, required %02h@%0d", wr_data, wr_addr, mon_e.d, mon_e.a);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic exp_write(input int a, input logic [7:0] d);
    wr_t e;
    e.a = AW'(a);
    e.d = d;
    exp_q.push_back(e);
    ref_mem[a] = d;
  endtask

  task automatic exp_clear();
    for (int a = 0; a < TOTAL; a++) exp_write(a, 8'h20);
  endtask

  task automatic exp_scroll();
    for (int a = 0; a < 1920; a++) exp_write(a, ref_mem[a + 80]);
    for (int a = 1920; a < TOTAL; a++) exp_write(a, 8'h20);
  endtask

  // Called and returns at a falling edge. The byte is offered for one rising edge.
  task automatic send(input logic [7:0] b);
    chk("ready_before_send", 32'(in_ready), 32'd1);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  // Counts falling-edge samples with in_ready low, starting with the current sample.
  task automatic wait_busy(output int n);
    n = 0;
    while (!in_ready && n < 6000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 6000) begin
      errors++;
      $display("FAIL busy_timeout: got no return to idle within %0d cycles, required idle", n);
    end
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;

    // Reset state
    #12;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'h20);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_cursor", 32'(cursor_pos), 32'd0);

    // Releasing reset starts a full-screen clear
    exp_clear();
    @(negedge clk);
    rst_n = 1'b1;
    wait_busy(n);
    chk("init_clear_busy", 32'(n), 32'd2000);
    chk("init_cursor", 32'(cursor_pos), 32'd0);
    settle();

    // "AB", CR, "C", then BS twice. Control bytes must not write.
    exp_write(0, 8'h41); send(8'h41);
    exp_write(1, 8'h42); send(8'h42);
    chk("cursor_after_AB", 32'(cursor_pos), 32'd2);
    send(8'h0D);
    chk("cursor_after_cr", 32'(cursor_pos), 32'd0);
    exp_write(0, 8'h43); send(8'h43);
    chk("cursor_after_C", 32'(cursor_pos), 32'd1);
    send(8'h01); send(8'h7F); send(8'h1B);
    chk("cursor_after_ignored", 32'(cursor_pos), 32'd1);
    send(8'h08);
    chk("cursor_after_bs1", 32'(cursor_pos), 32'd0);
    send(8'h08);
    chk("cursor_after_bs2", 32'(cursor_pos), 32'd0);

    // Fill row 0 and wrap to row 1 without scrolling
    for (int i = 0; i < 80; i++) begin
      exp_write(i, 8'h58);
      send(8'h58);
    end
    chk("cursor_after_row", 32'(cursor_pos), 32'd80);
    chk("no_scroll_ready", 32'(in_ready), 32'd1);

    // Move to the last row, preload row r with value r, then LF to scroll
    for (int i = 0; i < 23; i++) send(8'h0A);
    chk("cursor_last_row", 32'(cursor_pos), 32'd1920);
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    for (int i = 0; i < TOTAL; i++) ref_mem[i] = 8'(i / 80);
    exp_scroll();
    send(8'h0A);
    wait_busy(n);
    chk("lf_scroll_busy", 32'(n), 32'd2001);
    chk("cursor_after_lf_scroll", 32'(cursor_pos), 32'd1920);
    settle();
    for (int r = 0; r < 25; r++) begin
      bad = 0;
      for (int c = 0; c < 80; c++)
        if (mem[r*80 + c] !== ((r < 24) ? 8'(r + 1) : 8'h20)) bad++;
      chk($sformatf("scrolled_row%0d_bad_cells", r), 32'(bad), 32'd0);
    end

    // Wrap on the last row: the character lands at 1999, then the screen scrolls
    for (int i = 0; i < 79; i++) begin
      exp_write(1920 + i, 8'h5A);
      send(8'h5A);
    end
    chk("cursor_at_1999", 32'(cursor_pos), 32'd1999);
    exp_write(1999, 8'h41);
    exp_scroll();
    send(8'h41);
    wait_busy(n);
    chk("wrap_scroll_busy", 32'(n), 32'd2001);
    chk("cursor_after_wrap", 32'(cursor_pos), 32'd1920);
    settle();
    chk("mem_1919", 32'(mem[1919]), 32'h41);
    chk("mem_1840", 32'(mem[1840]), 32'h5A);
    chk("mem_0", 32'(mem[0]), 32'd2);
    chk("mem_1999", 32'(mem[1999]), 32'h20);
    exp_write(1920, 8'hC1); send(8'hC1);
    chk("cursor_after_inverse", 32'(cursor_pos), 32'd1921);

    // FF from the last row, then FF from cursor 500
    exp_clear();
    send(8'h0C);
    wait_busy(n);
    chk("ff1_busy", 32'(n), 32'd2000);
    chk("ff1_cursor", 32'(cursor_pos), 32'd0);
    for (int i = 0; i < 6; i++) send(8'h0A);
    for (int i = 0; i < 20; i++) begin
      exp_write(480 + i, 8'h61);
      send(8'h61);
    end
    chk("cursor_500", 32'(cursor_pos), 32'd500);
    exp_clear();
    send(8'h0C);
    wait_busy(n);
    chk("ff2_busy", 32'(n), 32'd2000);
    chk("ff2_cursor", 32'(cursor_pos), 32'd0);
    settle();
    chk("mem_499_blank", 32'(mem[499]), 32'h20);

    // Reset in the middle of a scroll aborts it. A full clear follows.
    for (int i = 0; i < 24; i++) send(8'h0A);
    exp_scroll();
    send(8'h0A);
    repeat (100) @(negedge clk);
    chk("scroll_wr_en_active", 32'(wr_en), 32'd1);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_cursor", 32'(cursor_pos), 32'd0);
    exp_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_busy(n);
    chk("abort_clear_busy", 32'(n), 32'd2000);
    settle();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
